// File: rtl/dbg_pkg.sv
// Shared definitions for the debug step controller: command bytes, FSM
// state encoding and the report snapshot layout.
package dbg_pkg;

    localparam logic [7:0] CMD_RUN    = 8'h43;
    localparam logic [7:0] CMD_STEP   = 8'h53;
    localparam logic [7:0] CMD_REPORT = 8'h52;
    localparam logic [7:0] CMD_BREAK  = 8'h42;

    localparam int unsigned REPORT_BYTES = 8;
    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned FIELD_W      = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        SEND = 2'd3
    } state_t;

    // Report payload, transmitted MSB-first: PC then cycle count.
    typedef struct packed {
        logic [FIELD_W-1:0] pc;
        logic [FIELD_W-1:0] cycles;
    } report_t;

endpackage

// File: rtl/dbg_report_ser.sv
// Report serializer: loads a snapshot and shifts it out one byte at a time
// over the tx valid/ready handshake. done_c marks acceptance of the last byte.
module dbg_report_ser
    import dbg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  report_t     snap,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        done_c
);

    localparam int unsigned SNAP_W = $bits(report_t);
    localparam int unsigned IDX_W  = $clog2(REPORT_BYTES);

    logic [SNAP_W-1:0] shreg;
    logic [IDX_W-1:0]  idx;

    assign done_c = tx_valid && tx_ready && (idx == IDX_W'(REPORT_BYTES - 1));

    // Byte shifter; tx_data only changes on load or on an accepted byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            idx      <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (load) begin
            tx_data  <= snap[SNAP_W-1 -: BYTE_W];
            shreg    <= {snap[SNAP_W-BYTE_W-1:0], BYTE_W'(0)};
            idx      <= '0;
            tx_valid <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            idx <= idx + IDX_W'(1);
            if (done_c) begin
                tx_valid <= 1'b0;
            end else begin
                tx_data <= shreg[SNAP_W-1 -: BYTE_W];
                shreg   <= shreg << BYTE_W;
            end
        end
    end

endmodule

// File: rtl/dbg_step_ctrl.sv
// Debug step controller: runs or single-steps the pipeline via db_we under
// UART commands and reports PC plus executed-cycle count when it stops.
// Optional watchdog on continuous runs: define DBG_TIMEOUT_EN.
module dbg_step_ctrl
    import dbg_pkg::*;
#(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned CYCLE_W   = 32,
    parameter logic [31:0] RUN_LIMIT = 32'd1000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      cmd_data,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            halt_in,
    input  logic [PC_W-1:0] pc_in,
    output logic            db_we,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic            halted,
    output logic            bad_cmd
`ifdef DBG_TIMEOUT_EN
    ,
    output logic            run_timeout
`endif
);

    state_t               state, state_nxt;
    logic                 cmd_acc_c;
    logic                 bad_c;
    logic                 halt_set_c;
    logic                 load_c;
    logic                 entry_q;
    logic                 ser_done_c;
    logic [CYCLE_W-1:0]   cycle_cnt;
    report_t              snap_c;

`ifdef DBG_TIMEOUT_EN
    logic                 to_c;
    logic [31:0]          run_cnt;
`else
    logic                 unused_run_limit;
    assign unused_run_limit = ^RUN_LIMIT;
`endif

    assign cmd_acc_c = cmd_valid && cmd_ready;
    assign snap_c    = '{pc: FIELD_W'(pc_in), cycles: FIELD_W'(cycle_cnt)};

    // Next-state and per-cycle control decode.
    always_comb begin
        state_nxt  = state;
        bad_c      = 1'b0;
        halt_set_c = 1'b0;
        load_c     = 1'b0;
`ifdef DBG_TIMEOUT_EN
        to_c       = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (cmd_acc_c) begin
                    case (cmd_data)
                        CMD_RUN:    if (halted) bad_c = 1'b1; else state_nxt = RUN;
                        CMD_STEP:   if (halted) bad_c = 1'b1; else state_nxt = STEP;
                        CMD_REPORT: state_nxt = SEND;
                        default:    bad_c = 1'b1;
                    endcase
                end
            end
            RUN: begin
                if (halt_in) begin
                    halt_set_c = 1'b1;
                    state_nxt  = SEND;
                end else if (cmd_acc_c && cmd_data == CMD_BREAK) begin
                    state_nxt = SEND;
`ifdef DBG_TIMEOUT_EN
                end else if (run_cnt == RUN_LIMIT - 32'd1) begin
                    to_c      = 1'b1;
                    state_nxt = SEND;
`endif
                end
            end
            STEP: begin
                halt_set_c = halt_in;
                state_nxt  = SEND;
            end
            SEND: begin
                load_c = entry_q;
                if (ser_done_c) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, registered outputs and cycle accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            entry_q   <= 1'b0;
            db_we     <= 1'b0;
            cmd_ready <= 1'b0;
            bad_cmd   <= 1'b0;
            halted    <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            state     <= state_nxt;
            entry_q   <= (state_nxt == SEND) && (state != SEND);
            db_we     <= (state_nxt == RUN) || (state_nxt == STEP);
            cmd_ready <= (state_nxt == IDLE) || (state_nxt == RUN);
            bad_cmd   <= bad_c;
            halted    <= halted | halt_set_c;
            if (state == RUN || state == STEP) cycle_cnt <= cycle_cnt + CYCLE_W'(1);
        end
    end

`ifdef DBG_TIMEOUT_EN
    // Run-segment watchdog counter and timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt     <= '0;
            run_timeout <= 1'b0;
        end else begin
            run_timeout <= to_c;
            if (state != RUN && state_nxt == RUN) run_cnt <= '0;
            else if (state == RUN)                run_cnt <= run_cnt + 32'd1;
        end
    end
`endif

    dbg_report_ser u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (load_c),
        .snap     (snap_c),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .done_c   (ser_done_c)
    );

endmodule

// File: tb/tb_dbg_step_ctrl.sv
// Bench for dbg_step_ctrl: a per-cycle vector table for reset, single step
// and bad-byte handling, then hand-written run/break/stall/reset sequences.
module tb_dbg_step_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        halt_in;
    logic [31:0] pc_in;
    logic        db_we;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halted;
    logic        bad_cmd;
`ifdef DBG_TIMEOUT_EN
    logic        run_timeout;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dbg_step_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .halt_in   (halt_in),
        .pc_in     (pc_in),
        .db_we     (db_we),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .halted    (halted),
        .bad_cmd   (bad_cmd)
`ifdef DBG_TIMEOUT_EN
        ,
        .run_timeout (run_timeout)
`endif
    );

    typedef struct {
        logic        rst;
        logic        cv;
        logic [7:0]  cd;
        logic        halt;
        logic        txr;
        logic [31:0] pc;
        logic        e_we;
        logic        e_rdy;
        logic        e_bad;
        logic        e_tv;
        logic [7:0]  e_td;
        logic        chk_td;
        logic        e_halted;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic cv, input logic [7:0] cd,
                                input logic h, input logic txr, input logic [31:0] pc,
                                input logic we, input logic rdy, input logic bad,
                                input logic tv, input logic [7:0] td, input logic ctd,
                                input logic hl);
        vec_t v;
        v.rst = r; v.cv = cv; v.cd = cd; v.halt = h; v.txr = txr; v.pc = pc;
        v.e_we = we; v.e_rdy = rdy; v.e_bad = bad; v.e_tv = tv; v.e_td = td;
        v.chk_td = ctd; v.e_halted = hl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cmd_valid = 1'b0; halt_in = 1'b0; tx_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send_cmd(input logic [7:0] b);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_data  = b;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic recv_report(input int stall, output logic [63:0] r);
        logic [7:0] d;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            int n = 0;
            while (!tx_valid && n < 20) begin
                tick();
                n++;
            end
            chk("tx_valid_wait", 64'(tx_valid), 64'd1);
            d = tx_data;
            for (int s = 0; s < stall; s++) begin
                tick();
                chk("stall_valid", 64'(tx_valid), 64'd1);
                chk("stall_data", 64'(tx_data), 64'(d));
            end
            tx_ready = 1'b1;
            tick();
            tx_ready = 1'b0;
            r = {r[55:0], d};
        end
        chk("tx_valid_end", 64'(tx_valid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        vec_t        tbl[15];
        logic [63:0] r;
        int          n;

        rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; halt_in = 1'b0;
        tx_ready = 1'b0; pc_in = 32'h4;

        //              rst cv cd     h txr pc     we rdy bad tv td     ctd hl
        tbl[0]  = mk(1, 0, 8'h00, 0, 0, 32'h4, 0, 0, 0, 0, 8'h00, 1, 0);
        tbl[1]  = mk(0, 0, 8'h00, 0, 0, 32'h4, 0, 1, 0, 0, 8'h00, 0, 0);
        tbl[2]  = mk(0, 1, 8'h53, 0, 0, 32'h4, 1, 0, 0, 0, 8'h00, 0, 0);
        tbl[3]  = mk(0, 0, 8'h00, 0, 0, 32'h4, 0, 0, 0, 0, 8'h00, 0, 0);
        tbl[4]  = mk(0, 0, 8'h00, 0, 1, 32'h4, 0, 0, 0, 1, 8'h00, 1, 0);
        tbl[5]  = mk(0, 0, 8'h00, 0, 1, 32'h4, 0, 0, 0, 1, 8'h00, 1, 0);
        tbl[6]  = mk(0, 0, 8'h00, 0, 1, 32'h4, 0, 0, 0, 1, 8'h00, 1, 0);
        tbl[7]  = mk(0, 0, 8'h00, 0, 1, 32'h4, 0, 0, 0, 1, 8'h04, 1, 0);
        tbl[8]  = mk(0, 0, 8'h00, 0, 1, 32'h4, 0, 0, 0, 1, 8'h00, 1, 0);
        tbl[9]  = mk(0, 0, 8'h00, 0, 1, 32'h4, 0, 0, 0, 1, 8'h00, 1, 0);
        tbl[10] = mk(0, 0, 8'h00, 0, 1, 32'h4, 0, 0, 0, 1, 8'h00, 1, 0);
        tbl[11] = mk(0, 0, 8'h00, 0, 1, 32'h4, 0, 0, 0, 1, 8'h01, 1, 0);
        tbl[12] = mk(0, 0, 8'h00, 0, 1, 32'h4, 0, 1, 0, 0, 8'h00, 0, 0);
        tbl[13] = mk(0, 1, 8'h7A, 0, 0, 32'h4, 0, 1, 1, 0, 8'h00, 0, 0);
        tbl[14] = mk(0, 0, 8'h00, 0, 0, 32'h4, 0, 1, 0, 0, 8'h00, 0, 0);

        // Reset, single step, bad byte in IDLE
        for (int i = 0; i < 15; i++) begin
            rst = tbl[i].rst; cmd_valid = tbl[i].cv; cmd_data = tbl[i].cd;
            halt_in = tbl[i].halt; tx_ready = tbl[i].txr; pc_in = tbl[i].pc;
            tick();
            chk($sformatf("v%0d_db_we", i), 64'(db_we), 64'(tbl[i].e_we));
            chk($sformatf("v%0d_cmd_ready", i), 64'(cmd_ready), 64'(tbl[i].e_rdy));
            chk($sformatf("v%0d_bad_cmd", i), 64'(bad_cmd), 64'(tbl[i].e_bad));
            chk($sformatf("v%0d_tx_valid", i), 64'(tx_valid), 64'(tbl[i].e_tv));
            chk($sformatf("v%0d_halted", i), 64'(halted), 64'(tbl[i].e_halted));
            if (tbl[i].chk_td)
                chk($sformatf("v%0d_tx_data", i), 64'(tx_data), 64'(tbl[i].e_td));
        end
        cmd_valid = 1'b0; tx_ready = 1'b0;

        // Run until halt on the 10th write cycle
        do_reset();
        pc_in = 32'h0000_1000;
        send_cmd(8'h43);
        for (int i = 1; i <= 10; i++) begin
            chk("run_we", 64'(db_we), 64'd1);
            if (i == 10) halt_in = 1'b1;
            tick();
        end
        halt_in = 1'b0;
        chk("halt_we_off", 64'(db_we), 64'd0);
        chk("halt_halted", 64'(halted), 64'd1);
        chk("halt_tv_entry", 64'(tx_valid), 64'd0);
        tick();
        chk("halt_tv_latency", 64'(tx_valid), 64'd1);
        recv_report(0, r);
        chk("halt_report", r, {32'h0000_1000, 32'd10});
        send_cmd(8'h43);
        chk("halted_run_bad", 64'(bad_cmd), 64'd1);
        chk("halted_run_we", 64'(db_we), 64'd0);
        tick();
        chk("halted_run_bad_off", 64'(bad_cmd), 64'd0);
        chk("halted_run_we2", 64'(db_we), 64'd0);

        // Break and halt in the same cycle on cycle 5
        do_reset();
        pc_in = 32'h0000_2000;
        send_cmd(8'h43);
        for (int i = 1; i <= 5; i++) begin
            chk("brk_run_we", 64'(db_we), 64'd1);
            if (i == 5) begin
                cmd_valid = 1'b1; cmd_data = 8'h42; halt_in = 1'b1;
            end
            tick();
        end
        cmd_valid = 1'b0; halt_in = 1'b0;
        chk("brk_halted", 64'(halted), 64'd1);
        chk("brk_bad", 64'(bad_cmd), 64'd0);
        recv_report(0, r);
        chk("brk_report", r, {32'h0000_2000, 32'd5});
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("brk_single_report", 64'(tx_valid), 64'd0);
        end
        chk("brk_idle_ready", 64'(cmd_ready), 64'd1);

        // Report with the transmitter stalling 3 cycles per byte
        pc_in = 32'hA5C3_0F18;
        send_cmd(8'h52);
        recv_report(3, r);
        chk("stall_report", r, {32'hA5C3_0F18, 32'd5});

        // Reset in the middle of a report
        pc_in = 32'h0000_0040;
        send_cmd(8'h52);
        n = 0;
        while (!tx_valid && n < 20) begin
            tick();
            n++;
        end
        chk("mid_tv_wait", 64'(tx_valid), 64'd1);
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        tx_ready = 1'b0;
        chk("mid_byte3_valid", 64'(tx_valid), 64'd1);
        chk("mid_byte3_data", 64'(tx_data), 64'h40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_tv", 64'(tx_valid), 64'd0);
        chk("mid_rst_halted", 64'(halted), 64'd0);
        chk("mid_rst_td", 64'(tx_data), 64'd0);
        chk("mid_rst_ready", 64'(cmd_ready), 64'd0);
        pc_in = 32'h1234_5678;
        send_cmd(8'h52);
        recv_report(1, r);
        chk("post_rst_report", r, {32'h1234_5678, 32'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dbg_step_ctrl.md
Name: dbg_step_ctrl

Overview:
- Debug-side controller that drives the pipeline write-enable `db_we` consumed by the PC and the other pipeline registers.
- Takes single-byte commands from the UART receiver over a valid/ready handshake and runs the processor continuously or for one cycle.
- When the processor stops, it captures the current PC and a cycle count and streams an 8-byte report to the UART transmitter over a valid/ready handshake.

Parameters:
- PC_W, 32, width of program counter snapshot.
- CYCLE_W, 32, width of executed-cycle counter.
- RUN_LIMIT, 32'd1000000, watchdog cycle limit. Used only with DBG_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd_data  in  8  command byte from UART receiver.
- cmd_valid  in  1  command byte available.
- cmd_ready  out  1  controller accepts command this cycle.
- halt_in  in  1  halt instruction retired; meaningful only while db_we=1.
- pc_in  in  PC_W  current PC register output.
- db_we  out  1  pipeline/PC write enable.
- tx_data  out  8  report byte.
- tx_valid  out  1  report byte available.
- tx_ready  in  1  transmitter accepts byte.
- halted  out  1  sticky: program reached halt.
- bad_cmd  out  1  one-cycle pulse when a command byte is rejected.

Behaviour:
- Reset (rst=1 at an edge, from any state): next state IDLE; db_we=0, cmd_ready=0 during the reset cycle, tx_valid=0, tx_data=0, halted=0, bad_cmd=0, cycle_cnt=0, byte index=0. Any transfer in progress is dropped.
- Commands, consumed on cmd_valid&&cmd_ready:
  - 'C' 0x43 run.
  - 'S' 0x53 step.
  - 'R' 0x52 report.
  - 'B' 0x42 break.
- IDLE:
  - cmd_ready=1, db_we=0.
  - 'C' goes to RUN; 'S' goes to STEP; 'R' goes to SEND.
  - 'C' or 'S' while halted=1: rejected, bad_cmd pulses the next cycle, stay IDLE.
  - 'B' or any unknown byte: rejected with bad_cmd pulse, stay IDLE.
- RUN:
  - db_we=1 every cycle; cycle_cnt increments each such cycle.
  - cmd_ready=1, but only 'B' has effect; other bytes are consumed and ignored, with no bad_cmd.
  - halt_in=1 sets halted=1 and goes to SEND.
  - Accepted 'B' goes to SEND.
  - halt_in and 'B' in the same cycle: halt takes precedence (halted=1), 'B' is consumed, go to SEND.
  - db_we falls to 0 in the first SEND cycle.
- STEP:
  - db_we=1 for exactly one cycle; cycle_cnt+1.
  - halt_in in that cycle sets halted.
  - Next state SEND.
  - cmd_ready=0.
- SEND:
  - On entry cycle, latch pc_in and cycle_cnt (value after its final increment) into the snapshot. pc_in is sampled in the entry cycle, after the last db_we write has landed.
  - cmd_ready=0, db_we=0.
  - Report is 8 bytes: PC MSB-first, then cycle_cnt MSB-first. PC_W/CYCLE_W below 32 are zero-extended to 32 bits.
  - tx_valid=1 from the cycle after entry. tx_data is stable while tx_valid && !tx_ready.
  - Byte index advances on tx_valid&&tx_ready. Acceptance of byte 7 returns to IDLE with tx_valid=0 the next cycle.
- Latency: command acceptance to first db_we=1 is 1 cycle; stop event to first tx_valid=1 is 2 cycles.
- cycle_cnt wraps modulo 2^CYCLE_W and is cleared only by rst.
- halted is cleared only by rst.

Optional Feature:
- Macro DBG_TIMEOUT_EN.
- Defined: adds output port run_timeout (1 bit) and a run-segment counter.
  - The counter clears on entering RUN and increments each RUN cycle.
  - When it reaches RUN_LIMIT with no halt or break, go to SEND and pulse run_timeout for one cycle. halted is not set.
  - halt_in takes precedence over timeout in the same cycle.
- Undefined: no port, no counter; RUN continues indefinitely.

Decomposition:
- Package dbg_pkg holds:
  - command byte constants (CMD_RUN, CMD_STEP, CMD_REPORT, CMD_BREAK);
  - state encoding (IDLE, RUN, STEP, SEND);
  - REPORT_BYTES=8.
- Sub-module dbg_report_ser: loads the 64-bit snapshot and shifts out bytes under the tx valid/ready handshake, with a done pulse back to the FSM.

Test Plan:
- Reset, then 'S' with pc_in=0x00000004 → exactly one db_we cycle; report bytes 00 00 00 04 00 00 00 01.
- 'C', halt_in asserted on the 10th db_we cycle → db_we high exactly 10 cycles; halted=1; report cycle count 0x0000000A; a following 'C' gives bad_cmd pulse and db_we stays 0.
- 'C', then 'B' on cycle 5 with halt_in=1 in the same cycle → halted=1; single report sent; cycle count 5.
- tx_ready held low 3 cycles on each byte → tx_data stable while stalled; all 8 bytes delivered in order.
- Byte 0x7A in IDLE → bad_cmd one cycle; no state change; db_we=0.
- rst asserted during byte 3 of a report → tx_valid=0 and halted=0 next cycle; a following 'R' reports cycle count 0.
